uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial-to-byte receiver on the rxd pin of top. Frame: 1 start, 8 data (LSB first), 1 stop, no parity.
//  Samples each bit at mid-bit and presents each byte on a valid/ready port.
//  The program/data loader downstream consumes that port.
//  Flags framing errors and overruns as single-cycle pulses.
// PARAMETERS
//  CLKS_PER_BIT  5  clk cycles per UART bit; legal range >=4. Default matches the 10 ns clk / 50 ns bit used in simulation.
//  SYNC_STAGES   2  flip-flop depth of the rxd synchroniser; legal range >=2.
// PORTS
//  clk      in   1  system clock, rising edge.
//  rst      in   1  asynchronous reset, active-low (0 = reset).
//  rxd      in   1  asynchronous serial input; idle high.
//  rdata    out  8  received byte; stable while rvalid=1.
//  rvalid   out  1  rdata holds an unconsumed byte.
//  rready   in   1  consumer accepts rdata when rvalid&&rready.
//  busy     out  1  1 while the FSM is in any state other than IDLE.
//  ferr     out  1  1-cycle pulse: stop bit sampled 0.
//  overrun  out  1  1-cycle pulse: byte dropped because the holding register was full.
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM=IDLE. rdata=0, rvalid=0, busy=0, ferr=0, overrun=0.
//   - All synchroniser flops=1, so there is no false start on release.
//   - A reset mid-frame abandons the frame; no partial byte is emitted.
//  rxd_s: rxd after SYNC_STAGES flops. HALF=(CLKS_PER_BIT-1)/2. cnt is a bit-period counter, $clog2(CLKS_PER_BIT) bits.
//  FSM states:
//   - IDLE: on rxd_s==0 -> START, cnt=0.
//   - START: cnt++. At cnt==HALF sample rxd_s:
//     - 1 = glitch -> IDLE, nothing reported.
//     - 0 -> DATA, cnt=0, bitidx=0.
//   - DATA: cnt++. At cnt==CLKS_PER_BIT-1 sample rxd_s into shreg[bitidx] (LSB first), cnt=0, bitidx++.
//     After bit 7 -> STOP.
//   - STOP: at cnt==CLKS_PER_BIT-1 sample rxd_s:
//     - 1 -> deliver shreg (see holding register below), then IDLE.
//     - 0 -> ferr pulse next cycle; byte discarded; go to BRK.
//   - BRK: wait for rxd_s==1, then IDLE. A held-low line yields exactly one ferr.
//  Latency: pin falling edge at cycle 0 -> rvalid=1 at cycle SYNC_STAGES+HALF+9*CLKS_PER_BIT+2 (=51 at defaults).
//  Holding register (1 entry):
//   - Accepted byte loads rdata, rvalid=1 next cycle.
//   - rvalid falls the cycle after rvalid&&rready unless a new byte loads that same cycle.
//   - Simultaneous handshake and delivery: new byte loads, rvalid stays 1, no overrun.
//   - Delivery while rvalid=1 and rready=0: new byte dropped, rdata unchanged, overrun pulse.
//  rdata never changes while rvalid=1 except by a same-cycle handshake+load.
//  Back-to-back frames: the next start bit is detectable in the cycle after the stop sample. No extra idle bit is required.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} uart_rx_state_t
//   - localparam UART_DATA_BITS = 8
//   - shared later with uart_tx.
//  Sub-module sync_ff #(STAGES): reset value 1, async active-low reset, used for the rxd synchroniser.
//  Everything else (FSM, counters, shift register, holding register) lives in uart_rx.
// TESTING (CLKS_PER_BIT=5, 10 ns clk; drive rxd at 50 ns per bit; rready=1 unless stated)
//  1. Bytes 0x04,0x0c,0x40,0xc0,0xff back-to-back -> rvalid once per byte, rdata in order, ferr=overrun=0,
//     rvalid 51 cycles after each start edge.
//  2. Low glitch on rxd of 1 cycle, then idle -> no rvalid, no ferr, busy returns to 0 within HALF+2 cycles.
//  3. Frame 0x55 with stop bit=0, then line high -> one ferr pulse, no rvalid; following 0x29 received correctly.
//  4. rready=0, send 0x01 then 0x76 -> rdata=0x01 held, one overrun pulse; rready=1 -> 0x01 consumed, rvalid falls.
//  5. rready pulsed in the exact cycle 0x44 is delivered while 0x00 is pending -> 0x00 consumed,
//     rdata=0x44, rvalid stays 1, no overrun.
//  6. rst=0 during bit 4 of a frame, released, then send 0x06 -> all outputs 0 during reset, no partial byte, 0x06 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants (receiver now, transmitter later).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Multi-stage synchroniser for an asynchronous level; resets to 1 so an idle-high line
// looks idle immediately after reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready holding register,
// with single-cycle framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      busy,
    output logic                      ferr,
    output logic                      overrun
);

    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

    logic                      rxd_s;
    uart_rx_state_t            state;
    logic [CNT_W-1:0]          cnt;
    logic [BIT_W-1:0]          bitidx;
    logic [UART_DATA_BITS-1:0] shreg;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Frame FSM plus holding register; later assignments to rvalid override the handshake clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitidx  <= '0;
            shreg   <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            busy    <= 1'b0;
            ferr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            ferr    <= 1'b0;
            overrun <= 1'b0;
            if (rvalid && rready) begin
                rvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(HALF)) begin
                        cnt    <= '0;
                        bitidx <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt           <= '0;
                        shreg[bitidx] <= rxd_s;
                        bitidx        <= bitidx + BIT_W'(1);
                        if (bitidx == BIT_W'(UART_DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // A byte may load only if the slot is empty or being drained this cycle.
                            if (!rvalid || rready) begin
                                rdata  <= shreg;
                                rvalid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state <= BRK;
                            ferr  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BRK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
